dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter that shares the single data memory between requester 0 (CPU load/store) and
//  requester 1 (loader/debug port). Sits between the requesters and the memory's address,
//  data_write, memo_read, memo_write and data_read pins.
//  Provides valid/ready request handshakes, round-robin or fixed-priority selection,
//  registered read responses and a lock for atomic read-modify-write.
// PARAMETERS
//  ADDR_W        16   memory address width
//  DATA_W        16   memory data width
//  PRIORITY_MODE 0    0 = round-robin; 1 = fixed priority, requester 0 always wins
//  LOCK_TIMEOUT  255  idle cycles of the lock owner before a forced release; 0 disables the timeout
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  rst_n          in   1       synchronous active-low reset
//  req_valid[1:0] in   2       per-requester request valid
//  req_we[1:0]    in   2       1 = write, 0 = read
//  req_lock[1:0]  in   2       request the lock with this transaction
//  req_addr0/1    in   ADDR_W  per-requester address
//  req_wdata0/1   in   DATA_W  per-requester write data
//  req_ready[1:0] out  2       grant; transaction accepted when valid & ready
//  rsp_valid[1:0] out  2       one-cycle pulse, read data available
//  rsp_rdata0/1   out  DATA_W  registered read data, held until the next response
//  mem_address    out  ADDR_W  to memory address
//  mem_data_write out  DATA_W  to memory data_write
//  mem_read       out  1       to memory memo_read
//  mem_write      out  1       to memory memo_write
//  mem_data_read  in   DATA_W  from memory data_read (combinational)
//  lock_timeout   out  1       one-cycle pulse when a lock is force-released
// BEHAVIOUR
//  - State: IDLE, LOCK0, LOCK1 (2-bit); last_grant register; lock idle counter (8-bit min).
//  - Reset (rst_n=0 at posedge): state=IDLE, last_grant=1, counter=0, rsp_valid=0, rsp_rdata*=0,
//    lock_timeout=0. While rst_n=0, req_ready=0, mem_read=0, mem_write=0, mem_address=0,
//    mem_data_write=0 (combinationally gated). A read accepted in the cycle reset asserts
//    gets no response.
//  - Selection (combinational, at most one bit of req_ready set):
//    - IDLE: a single valid requester wins. If both are valid: PRIORITY_MODE=1 picks 0;
//      PRIORITY_MODE=0 picks ~last_grant.
//    - LOCKn: only requester n is eligible. The other requester sees ready=0 even if valid.
//  - Memory drive: the winner's addr/wdata are muxed out; mem_write=win&we; mem_read=win&~we.
//    With no winner, all mem outputs are 0.
//  - Write is committed by the memory at the same posedge. A read accepted in cycle N captures
//    mem_data_read at that posedge into rsp_rdataW, with rsp_valid[W]=1 during N+1 only.
//  - Back-to-back: a new request may be accepted every cycle. Throughput is 1 per cycle.
//  - last_grant is updated to the winner on every accepted transaction.
//  - Lock transitions:
//    - IDLE -> LOCKn: accepted transaction from n with req_lock[n]=1.
//    - LOCKn -> IDLE: accepted transaction from n with req_lock[n]=0 (that transaction still
//      completes normally).
//    - LOCKn -> IDLE on timeout: counter resets to 0 on each accepted owner transaction and
//      increments each cycle req_valid[n]=0. When it reaches LOCK_TIMEOUT, go to IDLE, pulse
//      lock_timeout, and clear the counter.
//  - Lock re-request while already locked by the same owner keeps LOCKn.
//  - Addresses pass unmodified. Full ADDR_W range, wrap is the memory's concern.
//  - Requesters must hold valid/we/addr/wdata/lock stable until accepted. The arbiter does not
//    check this.
// TESTING
//  1. Reset: rst_n=0 with both valid -> ready=00, mem_write=0; after release, first contention grants 0.
//  2. Round-robin: both write continuously (r0 addr 0x0010 data 0xAAAA, r1 addr 0x0020 data 0xBBBB)
//     -> grants alternate 0,1,0,1; memory holds both values.
//  3. Read latency: r1 reads 0x0020 at cycle N -> rsp_valid[1]=1 at N+1 only; rsp_rdata1=0xBBBB.
//  4. Lock: r0 reads 0x0010 with lock=1, then writes 0xAAAB with lock=0 while r1 is valid
//     throughout -> r1 ready=0 until r0's unlocking write is accepted; r1 is granted the next cycle.
//  5. Timeout: LOCK_TIMEOUT=4; r0 locks and then idles, r1 valid -> lock_timeout pulses 4 cycles
//     later; r1 is granted the next cycle.
//  6. PRIORITY_MODE=1 with both valid for 3 cycles -> r0 granted all 3; r1 is not granted.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between requester 0 (CPU load/store)
//   and requester 1 (loader/debug). Each requester uses a valid/ready
//   handshake. When both compete, the winner is chosen round-robin or by
//   fixed priority. Read data is registered and returned one cycle after
//   acceptance. A requester may hold a lock for an atomic read-modify-write.
//   The lock is force-released after LOCK_TIMEOUT idle cycles of its owner.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/we/lock[1:0]     per-requester request, write enable, lock
//   req_addr0/1, req_wdata0/1  per-requester address and write data
//   req_ready[1:0]             grant (one-hot or zero)
//   rsp_valid[1:0]             one-cycle read-response pulse
//   rsp_rdata0/1               registered read data, held until next response
//   mem_address/data_write     to memory, winner's address and data
//   mem_read, mem_write        to memory strobes
//   mem_data_read              from memory (combinational read)
//   lock_timeout               one-cycle pulse on a forced lock release
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int PRIORITY_MODE = 0,
  parameter int LOCK_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [1:0]        req_lock,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata0,
  output logic [DATA_W-1:0] rsp_rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_write,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_read,
  output logic              lock_timeout
);

  // Counter is at least 8 bits, wider only if the timeout needs it.
  localparam int CNT_W = (LOCK_TIMEOUT > 255) ? $clog2(LOCK_TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_rsp_valid;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_lock_timeout;

  logic [1:0]        w_grant;
  logic              w_any;
  logic              w_sel;   // 1 when requester 1 is the winner
  logic              w_we;
  logic              w_lock;

  // NOTE: every output of a combinational block gets a default first so that
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_grant = 2'b00;
    // Gating on rst_n keeps the memory quiet while reset is held.
    if (rst_n) begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid == 2'b11) begin
            if (PRIORITY_MODE != 0) w_grant = 2'b01;
            else                    w_grant = r_last_grant ? 2'b01 : 2'b10;
          end else begin
            w_grant = req_valid;
          end
        end
        ST_LOCK0: w_grant = {1'b0, req_valid[0]};
        ST_LOCK1: w_grant = {req_valid[1], 1'b0};
        default:  w_grant = 2'b00;
      endcase
    end
  end

  assign w_any  = |w_grant;
  assign w_sel  = w_grant[1];
  assign w_we   = w_sel ? req_we[1]   : req_we[0];
  assign w_lock = w_sel ? req_lock[1] : req_lock[0];

  assign req_ready      = w_grant;
  assign mem_address    = w_any ? (w_sel ? req_addr1  : req_addr0)  : '0;
  assign mem_data_write = w_any ? (w_sel ? req_wdata1 : req_wdata0) : '0;
  assign mem_write      = w_any &  w_we;
  assign mem_read       = w_any & ~w_we;

  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata0   = r_rdata0;
  assign rsp_rdata1   = r_rdata1;
  assign lock_timeout = r_lock_timeout;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_last_grant   <= 1'b1;
      r_cnt          <= '0;
      r_rsp_valid    <= 2'b00;
      r_rdata0       <= '0;
      r_rdata1       <= '0;
      r_lock_timeout <= 1'b0;
    end else begin
      r_rsp_valid    <= w_grant & ~req_we;
      r_lock_timeout <= 1'b0;
      if (w_grant[0] && !req_we[0]) r_rdata0 <= mem_data_read;
      if (w_grant[1] && !req_we[1]) r_rdata1 <= mem_data_read;
      if (w_any) r_last_grant <= w_sel;

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_any && w_lock) r_state <= w_sel ? ST_LOCK1 : ST_LOCK0;
        end
        ST_LOCK0, ST_LOCK1: begin
          // Only the owner can win here, so no grant means the owner is idle.
          if (w_any) begin
            r_cnt <= '0;
            if (!w_lock) r_state <= ST_IDLE;
          end else if (LOCK_TIMEOUT != 0) begin
            if (r_cnt == TIMEOUT_LAST) begin
              r_state        <= ST_IDLE;
              r_cnt          <= '0;
              r_lock_timeout <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
